// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the table-driven sequencer: controller states,
// default widths and the table-entry layout.
// Optional feature macro: PARITY_EN adds the ERR controller state.
package fsm_seq_pkg;

    localparam int STATE_W_DEF = 3;
    localparam int IN_W_DEF    = 2;
    localparam int OUT_W_DEF   = 3;
    localparam int CNT_W_DEF   = 8;
    localparam int ADDR_W_DEF  = IN_W_DEF + STATE_W_DEF;
    localparam int ENTRY_W_DEF = STATE_W_DEF + OUT_W_DEF;

    // Controller states; ERR exists only when table parity is built in.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
`ifdef PARITY_EN
        ,
        ERR  = 2'd3
`endif
    } ctrl_t;

    // One table entry: next sequenced state in the upper bits, output below.
    typedef struct packed {
        logic [STATE_W_DEF-1:0] nxt;
        logic [OUT_W_DEF-1:0]   out;
    } entry_t;

endpackage

// File: rtl/fsm_seq_table.sv
// Transition/output table of the sequencer: one synchronous write port,
// one combinational read port. Contents have no reset.
// Optional feature macro: PARITY_EN stores an even-parity bit per entry
// and flags a mismatch on the read port.
module fsm_seq_table
    import fsm_seq_pkg::*;
#(
    parameter int AW = ADDR_W_DEF,
    parameter int DW = ENTRY_W_DEF
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
`ifdef PARITY_EN
    input  logic          perr_inj,
    output logic          rperr,
`endif
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_r [DEPTH];

    // Store the written entry; the table deliberately survives reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

`ifdef PARITY_EN
    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic parity_even(input logic [DW-1:0] d);
        return ^d;
    endfunction

    logic par_r [DEPTH];

    // Parity bit written alongside the entry, optionally corrupted on request.
    always_ff @(posedge clk) begin
        if (we) begin
            par_r[waddr] <= parity_even(wdata) ^ perr_inj;
        end
    end

    assign rperr = (par_r[raddr] != parity_even(rdata));
`endif

endmodule

// File: rtl/fsm_seq_ctrl.sv
// Table-driven sequencer controller. In IDLE the table can be loaded; a
// start launches a run that walks table[{a, state}] once per clock until
// the halt state, the step limit or a stop ends it.
// Optional feature macro: PARITY_EN adds table parity, the cfg_perr_inj
// input, the err output and the sticky ERR controller state.
module fsm_seq_ctrl
    import fsm_seq_pkg::*;
#(
    parameter int STATE_W = STATE_W_DEF,
    parameter int IN_W    = IN_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    cfg_we,
    input  logic [IN_W+STATE_W-1:0] cfg_addr,
    input  logic [STATE_W+OUT_W-1:0] cfg_data,
    input  logic                    start,
    input  logic                    stop,
    input  logic [CNT_W-1:0]        step_limit,
    input  logic [STATE_W-1:0]      halt_state,
    input  logic [IN_W-1:0]         a,
`ifdef PARITY_EN
    input  logic                    cfg_perr_inj,
    output logic                    err,
`endif
    output logic [OUT_W-1:0]        saida,
    output logic [STATE_W-1:0]      state,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        steps
);

    localparam int ADDR_W  = IN_W + STATE_W;
    localparam int ENTRY_W = STATE_W + OUT_W;

    ctrl_t              ctrl_r,  ctrl_nx_s;
    logic [STATE_W-1:0] state_r, state_nx_s;
    logic [OUT_W-1:0]   saida_r, saida_nx_s;
    logic [CNT_W-1:0]   steps_r, steps_nx_s;
    logic               busy_r,  busy_nx_s;
    logic               done_r,  done_nx_s;

    logic               tbl_we_s;
    logic [ADDR_W-1:0]  rd_addr_s;
    logic [ENTRY_W-1:0] rd_entry_s;
    logic [STATE_W-1:0] rd_next_s;
    logic [OUT_W-1:0]   rd_out_s;
    logic [CNT_W-1:0]   steps_inc_s;
    logic               limit_hit_s;
    logic               halt_hit_s;
    logic               run_end_s;

`ifdef PARITY_EN
    logic               err_r, err_nx_s;
    logic               rd_perr_s;
`endif

    fsm_seq_table #(
        .AW (ADDR_W),
        .DW (ENTRY_W)
    ) u_table (
        .clk      (clk),
        .we       (tbl_we_s),
        .waddr    (cfg_addr),
        .wdata    (cfg_data),
`ifdef PARITY_EN
        .perr_inj (cfg_perr_inj),
        .rperr    (rd_perr_s),
`endif
        .raddr    (rd_addr_s),
        .rdata    (rd_entry_s)
    );

    assign rd_addr_s = {a, state_r};
    assign rd_next_s = rd_entry_s[ENTRY_W-1:OUT_W];
    assign rd_out_s  = rd_entry_s[OUT_W-1:0];

    // Step counter sticks at all-ones instead of wrapping.
    assign steps_inc_s = (steps_r == {CNT_W{1'b1}}) ? steps_r
                                                    : steps_r + {{(CNT_W-1){1'b0}}, 1'b1};

    // Compared one bit wider so the +1 can never wrap into a false match.
    assign limit_hit_s = (step_limit != {CNT_W{1'b0}}) &&
                         (({1'b0, steps_r} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, step_limit});
    assign halt_hit_s  = (rd_next_s == halt_state);
    assign run_end_s   = halt_hit_s || limit_hit_s || stop;

    // Next controller state and next values of every registered output.
    always_comb begin
        ctrl_nx_s  = ctrl_r;
        state_nx_s = state_r;
        saida_nx_s = saida_r;
        steps_nx_s = steps_r;
        busy_nx_s  = 1'b0;
        done_nx_s  = 1'b0;
        tbl_we_s   = 1'b0;
`ifdef PARITY_EN
        err_nx_s   = err_r;
`endif
        case (ctrl_r)
            IDLE: begin
                tbl_we_s = cfg_we;
                if (start) begin
                    ctrl_nx_s  = RUN;
                    state_nx_s = {STATE_W{1'b0}};
                    saida_nx_s = {OUT_W{1'b0}};
                    steps_nx_s = {CNT_W{1'b0}};
                    busy_nx_s  = 1'b1;
                end else begin
                    ctrl_nx_s  = IDLE;
                end
            end
            RUN: begin
`ifdef PARITY_EN
                if (rd_perr_s) begin
                    // Corrupted entry: freeze the datapath and latch the error.
                    ctrl_nx_s = ERR;
                    err_nx_s  = 1'b1;
                end else
`endif
                begin
                    // The final step is applied even when the run ends here.
                    state_nx_s = rd_next_s;
                    saida_nx_s = rd_out_s;
                    steps_nx_s = steps_inc_s;
                    if (run_end_s) begin
                        ctrl_nx_s = DONE;
                        done_nx_s = 1'b1;
                    end else begin
                        ctrl_nx_s = RUN;
                        busy_nx_s = 1'b1;
                    end
                end
            end
            DONE: begin
                ctrl_nx_s = IDLE;
            end
`ifdef PARITY_EN
            ERR: begin
                ctrl_nx_s = ERR;
                err_nx_s  = 1'b1;
            end
`endif
            default: begin
                ctrl_nx_s = IDLE;
            end
        endcase
    end

    // Controller and output registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!res) begin
            ctrl_r  <= IDLE;
            state_r <= {STATE_W{1'b0}};
            saida_r <= {OUT_W{1'b0}};
            steps_r <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef PARITY_EN
            err_r   <= 1'b0;
`endif
        end else begin
            ctrl_r  <= ctrl_nx_s;
            state_r <= state_nx_s;
            saida_r <= saida_nx_s;
            steps_r <= steps_nx_s;
            busy_r  <= busy_nx_s;
            done_r  <= done_nx_s;
`ifdef PARITY_EN
            err_r   <= err_nx_s;
`endif
        end
    end

    assign saida = saida_r;
    assign state = state_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign steps = steps_r;
`ifdef PARITY_EN
    assign err   = err_r;
`endif

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Self-checking bench for fsm_seq_ctrl: a behavioural table/sequencer
// model pushes the expected per-cycle outputs into a queue, which is popped
// and compared one cycle at a time as the DUT runs.
module tb_fsm_seq_ctrl;
    import fsm_seq_pkg::*;

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] sa;
        logic [7:0] stp;
        logic       bsy;
        logic       dn;
    } obs_t;

    logic       clk = 1'b0;
    logic       res;
    logic       cfg_we;
    logic [4:0] cfg_addr;
    logic [5:0] cfg_data;
    logic       start;
    logic       stop;
    logic [7:0] step_limit;
    logic [2:0] halt_state;
    logic [1:0] a;
    logic [2:0] saida;
    logic [2:0] state;
    logic       busy;
    logic       done;
    logic [7:0] steps;
`ifdef PARITY_EN
    logic       cfg_perr_inj;
    logic       err;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    obs_t exp_q[$];
    logic [5:0] model_tbl [32];

    fsm_seq_ctrl dut (
        .clk        (clk),
        .res        (res),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .start      (start),
        .stop       (stop),
        .step_limit (step_limit),
        .halt_state (halt_state),
        .a          (a),
`ifdef PARITY_EN
        .cfg_perr_inj (cfg_perr_inj),
        .err          (err),
`endif
        .saida      (saida),
        .state      (state),
        .busy       (busy),
        .done       (done),
        .steps      (steps)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [5:0] data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        tick();
        cfg_we   = 1'b0;
        model_tbl[addr] = data;
    endtask

    task automatic test_reset();
        res = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({state, saida, steps, busy, done} !== 16'h0000) begin
            n_errors++;
            $display("FAIL reset: state=%0d saida=%0d steps=%0d busy=%0b done=%0b, required all 0",
                     state, saida, steps, busy, done);
        end
        res = 1'b1;
        tick();
    endtask

    // Builds expected outputs with a model, then runs the DUT against them.
    task automatic do_run(input string name, input logic [7:0] limit, input logic [2:0] halt,
                          input int stop_at, input logic inject,
                          input logic [7:0] exp_steps, input logic [2:0] exp_state);
        logic [2:0] m_st    = 3'd0;
        logic [2:0] m_sa    = 3'd0;
        logic [7:0] m_steps = 8'd0;
        logic [5:0] e;
        bit         fin     = 1'b0;
        int         idx;
        int         done_cnt = 0;
        obs_t       o;
        obs_t       x;

        step_limit = limit;
        halt_state = halt;
        exp_q.push_back('{3'd0, 3'd0, 8'd0, 1'b1, 1'b0});
        for (int k = 1; k <= 400 && !fin; k++) begin
            e       = model_tbl[{a, m_st}];
            m_st    = e[5:3];
            m_sa    = e[2:0];
            if (m_steps != 8'hFF) m_steps = m_steps + 8'd1;
            fin     = (m_st == halt) || (limit != 8'd0 && m_steps == limit) || (k == stop_at);
            exp_q.push_back('{m_st, m_sa, m_steps, !fin, fin});
        end
        exp_q.push_back('{m_st, m_sa, m_steps, 1'b0, 1'b0});

        start = 1'b1;
        idx   = 0;
        while (exp_q.size() > 0) begin
            if (idx > 0) begin
                stop  = (idx == stop_at) ? 1'b1 : 1'b0;
                if (inject && idx == stop_at) begin
                    cfg_we   = 1'b1;
                    cfg_addr = 5'd0;
                    cfg_data = 6'o77;
                    start    = 1'b1;
                end
            end
            tick();
            start  = 1'b0;
            stop   = 1'b0;
            cfg_we = 1'b0;
            x = exp_q.pop_front();
            o = '{state, saida, steps, busy, done};
            if (done === 1'b1) done_cnt++;
            n_checks++;
            if (o !== x) begin
                n_errors++;
                $display("FAIL %s cycle %0d: got st=%0d sa=%0d steps=%0d busy=%0b done=%0b, required st=%0d sa=%0d steps=%0d busy=%0b done=%0b",
                         name, idx, o.st, o.sa, o.stp, o.bsy, o.dn, x.st, x.sa, x.stp, x.bsy, x.dn);
            end
            idx++;
        end

        n_checks++;
        if (done_cnt != 1) begin
            n_errors++;
            $display("FAIL %s done_pulses: got %0d, required 1", name, done_cnt);
        end
        n_checks++;
        if (steps !== exp_steps) begin
            n_errors++;
            $display("FAIL %s final_steps: got %0d, required %0d", name, steps, exp_steps);
        end
        n_checks++;
        if (state !== exp_state) begin
            n_errors++;
            $display("FAIL %s final_state: got %0d, required %0d", name, state, exp_state);
        end
    endtask

    task automatic test_limit_run();
        a = 2'd0;
        do_run("limit_run", 8'd5, 3'd7, 0, 1'b0, 8'd5, 3'd2);
    endtask

    task automatic test_halt_run();
        a = 2'd0;
        do_run("halt_run", 8'd0, 3'd2, 0, 1'b0, 8'd2, 3'd2);
    endtask

    task automatic test_stop_run();
        a = 2'd0;
        do_run("stop_run", 8'd0, 3'd7, 3, 1'b1, 8'd3, 3'd0);
        do_run("rerun_after_stop", 8'd5, 3'd7, 0, 1'b0, 8'd5, 3'd2);
    endtask

    task automatic test_a_input();
        wr(5'd8,  6'o35);
        wr(5'd11, 6'o24);
        wr(5'd10, 6'o66);
        a = 2'd1;
        do_run("a_input_run", 8'd0, 3'd6, 0, 1'b0, 8'd3, 3'd6);
        a = 2'd0;
    endtask

    task automatic test_saturation();
        a = 2'd0;
        do_run("saturation_run", 8'd0, 3'd7, 260, 1'b0, 8'd255, 3'd2);
    endtask

    task automatic test_mid_reset();
        obs_t o;
        obs_t x;
        a          = 2'd0;
        step_limit = 8'd5;
        halt_state = 3'd7;
        exp_q.push_back('{3'd0, 3'd0, 8'd0, 1'b1, 1'b0});
        exp_q.push_back('{3'd1, 3'd0, 8'd1, 1'b1, 1'b0});
        exp_q.push_back('{3'd0, 3'd0, 8'd0, 1'b0, 1'b0});
        exp_q.push_back('{3'd0, 3'd0, 8'd0, 1'b0, 1'b0});
        for (int i = 0; i < 4; i++) begin
            start = (i == 0) ? 1'b1 : 1'b0;
            res   = (i == 2) ? 1'b0 : 1'b1;
            tick();
            start = 1'b0;
            res   = 1'b1;
            x = exp_q.pop_front();
            o = '{state, saida, steps, busy, done};
            n_checks++;
            if (o !== x) begin
                n_errors++;
                $display("FAIL mid_reset cycle %0d: got st=%0d sa=%0d steps=%0d busy=%0b done=%0b, required st=%0d sa=%0d steps=%0d busy=%0b done=%0b",
                         i, o.st, o.sa, o.stp, o.bsy, o.dn, x.st, x.sa, x.stp, x.bsy, x.dn);
            end
        end
        do_run("rerun_after_reset", 8'd5, 3'd7, 0, 1'b0, 8'd5, 3'd2);
    endtask

`ifdef PARITY_EN
    task automatic test_parity();
        res = 1'b0;
        tick();
        res = 1'b1;
        cfg_perr_inj = 1'b1;
        wr(5'd1, 6'o21);
        cfg_perr_inj = 1'b0;
        a          = 2'd0;
        step_limit = 8'd0;
        halt_state = 3'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({err, state, busy, done, steps} !== {1'b1, 3'd1, 1'b0, 1'b0, 8'd1}) begin
                n_errors++;
                $display("FAIL parity_err cycle %0d: err=%0b state=%0d busy=%0b done=%0b steps=%0d, required err=1 state=1 busy=0 done=0 steps=1",
                         i, err, state, busy, done, steps);
            end
            tick();
        end
        res = 1'b0;
        tick();
        res = 1'b1;
        n_checks++;
        if (err !== 1'b0) begin
            n_errors++;
            $display("FAIL parity_reset: err=%0b, required 0", err);
        end
        wr(5'd1, 6'o21);
    endtask
`endif

    initial begin
        res        = 1'b0;
        cfg_we     = 1'b0;
        cfg_addr   = 5'd0;
        cfg_data   = 6'd0;
        start      = 1'b0;
        stop       = 1'b0;
        step_limit = 8'd0;
        halt_state = 3'd7;
        a          = 2'd0;
`ifdef PARITY_EN
        cfg_perr_inj = 1'b0;
`endif
        for (int i = 0; i < 32; i++) model_tbl[i] = 6'd0;

        test_reset();
        for (int i = 0; i < 32; i++) wr(i[4:0], 6'd0);
        wr(5'd0, 6'o10);
        wr(5'd1, 6'o21);
        wr(5'd2, 6'o02);
        test_limit_run();
        test_halt_run();
        test_stop_run();
        test_mid_reset();
        test_a_input();
        test_saturation();
`ifdef PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fsm_seq_ctrl.md
FSM_SEQ_CTRL -- requirements
Module: fsm_seq_ctrl

Interface
REQ-001 Parameter STATE_W, default 3, width of sequenced state and of halt_state.
REQ-002 Parameter IN_W, default 2, width of input a; table depth is 2^(IN_W+STATE_W) (32).
REQ-003 Parameter OUT_W, default 3, width of saida.
REQ-004 Parameter CNT_W, default 8, width of steps and step_limit.
REQ-005 Port clk  in  1  the only clock; all logic on its rising edge.
REQ-006 Port res  in  1  reset, synchronous and active-low.
REQ-007 Port cfg_we  in  1  table write strobe.
REQ-008 Port cfg_addr  in  5  table write address, {a, state}.
REQ-009 Port cfg_data  in  6  entry: [5:3] next state, [2:0] output.
REQ-010 Port start  in  1  begin a run; sampled only in IDLE.
REQ-011 Port stop  in  1  abort a run; sampled only in RUN.
REQ-012 Port step_limit  in  8  maximum steps per run; 0 means unlimited.
REQ-013 Port halt_state  in  3  the run ends when the next state equals this value.
REQ-014 Port a  in  2  input of the sequenced machine.
REQ-015 Port saida  out  3  registered table output.
REQ-016 Port state  out  3  current sequenced state.
REQ-017 Port busy  out  1  high while in RUN.
REQ-018 Port done  out  1  one-cycle pulse when a run ends normally.
REQ-019 Port steps  out  8  number of steps taken in the current or last run.

Function
REQ-020 The controller states SHALL be IDLE, RUN and DONE, plus ERR only when PARITY_EN is defined.
REQ-021 In IDLE, when cfg_we=1, the block SHALL write cfg_data to table[cfg_addr] at the clock edge.
REQ-022 In any state other than IDLE, the block SHALL ignore and drop cfg_we.
REQ-023 In IDLE with start=1, on that edge the block SHALL go to RUN and clear state, steps and saida to 0; busy SHALL be high from the next cycle.
REQ-024 On each edge in RUN, the block SHALL read entry = table[{a, state}], load state with entry[5:3] and saida with entry[2:0], and increment steps, saturating at 255.
REQ-025 A RUN step SHALL go to DONE if entry[5:3]==halt_state, or step_limit!=0 and steps+1==step_limit, or stop=1; that final step is still applied.
REQ-026 When several end conditions occur together, the block SHALL produce exactly one transition to DONE.
REQ-027 In DONE, done SHALL be 1 for exactly one cycle; the block SHALL then return to IDLE while holding state, saida and steps.
REQ-028 The block SHALL ignore start outside IDLE and stop outside RUN.

Reset
REQ-029 With res=0 at an edge, the block SHALL set controller=IDLE, state=0, saida=0, steps=0, busy=0, done=0 and err=0, including in the middle of a run.
REQ-030 Reset SHALL NOT alter table contents.

Configuration
REQ-031 With PARITY_EN defined, each table entry SHALL store an extra even-parity bit computed on write.
REQ-032 With PARITY_EN defined, the block SHALL have an added input cfg_perr_inj (1 bit) that inverts the stored parity bit of the written entry.
REQ-033 With PARITY_EN defined, the block SHALL have an added output err (1 bit).
REQ-034 With PARITY_EN defined, a parity mismatch on a RUN read SHALL move the controller to ERR with no update to state, saida or steps.
REQ-035 In ERR, err SHALL be 1 and sticky, busy SHALL be 0 and done SHALL NOT pulse; only reset SHALL exit ERR.
REQ-036 Without PARITY_EN, the block SHALL have no parity storage, no cfg_perr_inj port and no err port.

Structure
REQ-037 The shared package fsm_seq_pkg SHALL hold the controller-state enum, the width constants and the table-entry typedef.
REQ-038 The table, with its write port, read port and parity logic, SHALL be the sub-module fsm_seq_table.

Verification
REQ-039 Reset: hold res=0 for 2 edges -> saida=0, state=0, busy=0, done=0, steps=0.
REQ-040 Limit run: write entry 0=6'o10, 1=6'o21, 2=6'o02; set a=0, halt_state=7, step_limit=5; pulse start -> state 1,2,0,1,2, saida 0,1,2,0,1, steps=5, one done pulse, then IDLE.
REQ-041 Halt run: same table, halt_state=2, step_limit=0 -> ends after 2 steps with state=2, steps=2, done pulsed once.
REQ-042 Stop run: step_limit=0, halt_state=7, stop=1 during step 3, cfg_we=1 to addr 0 in the same cycle -> ends with steps=3; entry 0 still reads 6'o10 on rerun.
REQ-043 Mid-run reset: res=0 at step 2 -> all outputs 0 next cycle; a rerun gives the same sequence as REQ-040.
REQ-044 With PARITY_EN: write entry 1 with cfg_perr_inj=1, then run -> err=1 at the second RUN edge, state stays 1, busy=0, no done pulse.
